// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready stage register with a two-entry skid buffer.
// Define PIPE_SKID_FLUSH_EN to add a synchronous squash input (flush).
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;
  logic             squash;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != TWO);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

`ifdef PIPE_SKID_FLUSH_EN
  assign squash = flush;
`else
  assign squash = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;
    if (squash) begin
      // Squash wins: drop everything, leave data regs untouched.
      state_d = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Elastic pipeline stage register with a valid/ready handshake on both sides.
- It is the receiving counterpart of the free-running stage flop. It accepts a word from the upstream producer and holds it until the downstream consumer takes it. It can back-pressure upstream without losing data.
- It carries a two-entry skid buffer so `in_ready` is a registered-state function with no combinational path from `out_ready`.
- Used between CPU pipeline stages, e.g. IF->ID, where ID can stall.

Parameters:
- `WIDTH`, default 32: payload width in bits.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: upstream presents a valid word.
- `in_ready`, output, 1: block can accept a word this cycle.
- `in_data`, input, `WIDTH`: upstream payload.
- `out_valid`, output, 1: `out_data` holds a valid word.
- `out_ready`, input, 1: downstream takes the word this cycle.
- `out_data`, output, `WIDTH`: payload to downstream.
- `flush`, input, 1: present only with `PIPE_SKID_FLUSH_EN`.

Behaviour:
- Definitions:
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready`.
  - Storage is a main register (drives `out_data`) and a skid register.
- Reset (`rst_n` low, asynchronous):
  - State goes to EMPTY.
  - Main and skid registers go to 0.
  - `out_valid = 0`, `out_data = 0`, `in_ready = 1`.
  - Upstream must not assert `in_valid` while `rst_n` is low; such a word is discarded.
  - Reset asserted mid-transfer drops all held words.
- Outputs from state only:
  - `out_valid = (state != EMPTY)`.
  - `in_ready = (state != TWO)`.
  - `out_data = main`.
- State EMPTY:
  - `in_fire`: main <= `in_data`, go to ONE.
  - Otherwise hold.
- State ONE:
  - `in_fire & out_fire`: main <= `in_data`, stay in ONE.
  - `in_fire & !out_fire`: skid <= `in_data`, go to TWO.
  - `!in_fire & out_fire`: go to EMPTY; main keeps its stale value.
  - Neither: hold.
- State TWO (`in_ready = 0`, so no `in_fire`):
  - `out_fire`: main <= skid, go to ONE.
  - Otherwise hold.
- Latency:
  - A word accepted at edge N appears on `out_data` with `out_valid = 1` after edge N.
  - Zero-bubble throughput of 1 word/cycle while `out_ready = 1`.
- Ordering: strict FIFO, no duplication, no loss.
- Stability: while `out_valid & !out_ready`, `out_data` must not change.
- Full boundary: in TWO, `in_ready` deasserts within the same cycle the state is entered. It reasserts the cycle after the first `out_fire`.
- Empty boundary: no bypass path. A word never appears at the output in the cycle it is accepted.

Optional Feature:
- Macro: `PIPE_SKID_FLUSH_EN`.
- Defined:
  - Adds input port `flush`.
  - When `flush = 1` at a rising edge, state goes to EMPTY regardless of `in_fire`/`out_fire`. Any simultaneous input word is dropped.
  - Data registers are not cleared.
  - Flush has priority over all transitions; used for branch/exception squash.
- Undefined:
  - No `flush` port.
  - Transitions are exactly as listed in Behaviour.

Test Plan:
- Reset: hold `rst_n = 0` mid-sim with the block in TWO -> `out_valid = 0`, `out_data = 0`, `in_ready = 1` immediately, before any clock edge.
- Streaming: `out_ready = 1`; drive `in_valid = 1` with 0x11, 0x22, 0x33 on consecutive cycles -> each appears one cycle after acceptance, no bubbles, `in_ready` constantly 1.
- Back-pressure:
  - Hold `out_ready = 0`, send 0xA0 then 0xA1 -> both accepted, `in_ready = 0` after the second. 0xA2 is held upstream; `out_data` stays 0xA0.
  - Release `out_ready` -> outputs 0xA0, 0xA1, 0xA2 in order; `in_ready` returns to 1 the cycle after the first `out_fire`.
- Drain: from ONE with `in_valid = 0`, pulse `out_ready = 1` for one cycle -> `out_valid` drops to 0 next cycle; `out_ready` toggling with no data causes no output.
- Random: random `in_valid`/`out_ready` for 10,000 cycles against a scoreboard FIFO -> every word delivered exactly once, in order; `out_data` stable whenever stalled.
- Flush (with `PIPE_SKID_FLUSH_EN`): in TWO holding 0xB0/0xB1, assert `flush` with `in_valid = 1` carrying 0xB2 -> next cycle `out_valid = 0`, `in_ready = 1`, and none of 0xB0/0xB1/0xB2 is ever delivered.
